// File: rtl/basilisk_writeback_arbiter_if.sv
// rtl/basilisk_writeback_arbiter_if.sv - result payload type and requester/writeback bundle
//
// basilisk_writeback_pkg
//   basilisk_writeback_result_t : one execution-unit result word
//
// basilisk_writeback_arbiter_if #(NUM_PORTS, PORT_INDEX_WIDTH)
//   result_valid     [NUM_PORTS]   requester -> arbiter, per-requester valid
//   result_ready     [NUM_PORTS]   arbiter -> requester, combinational grant
//   result_data      [NUM_PORTS]   requester -> arbiter, per-requester payload
//   writeback_valid                arbiter -> register file, output register full
//   writeback_ready                register file -> arbiter, write port accepts
//   writeback_data                 arbiter -> register file, registered payload
//   writeback_source               arbiter -> register file, requester index of payload
//   writeback_count  [16]          arbiter -> observer, delivered results (wrapping)
//
//   modport slave  : the arbiter's view
//   modport master : the requesters / register file view

package basilisk_writeback_pkg;

    typedef logic [31:0] basilisk_writeback_result_t;

endpackage

interface basilisk_writeback_arbiter_if
    import basilisk_writeback_pkg::*;
#(
    parameter int NUM_PORTS        = 5,
    parameter int PORT_INDEX_WIDTH = $clog2(NUM_PORTS)
);

    logic [NUM_PORTS-1:0]                            result_valid;
    logic [NUM_PORTS-1:0]                            result_ready;
    basilisk_writeback_result_t [NUM_PORTS-1:0]      result_data;
    logic                                            writeback_valid;
    logic                                            writeback_ready;
    basilisk_writeback_result_t                      writeback_data;
    logic [PORT_INDEX_WIDTH-1:0]                     writeback_source;
    logic [15:0]                                     writeback_count;

    modport slave (
        input  result_valid,
        output result_ready,
        input  result_data,
        output writeback_valid,
        input  writeback_ready,
        output writeback_data,
        output writeback_source,
        output writeback_count
    );

    modport master (
        output result_valid,
        input  result_ready,
        output result_data,
        input  writeback_valid,
        output writeback_ready,
        input  writeback_data,
        input  writeback_source,
        input  writeback_count
    );

endinterface

// File: rtl/basilisk_writeback_arbiter.sv
// rtl/basilisk_writeback_arbiter.sv - round-robin arbiter funnelling results into one writeback register
//
// Ports
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : basilisk_writeback_arbiter_if.slave
//          result_valid/result_ready/result_data from NUM_PORTS requesters,
//          writeback_valid/writeback_ready/writeback_data/writeback_source to the
//          register file, writeback_count of delivered results.
//
// A single output register sits between the requesters and the register-file
// write port. It may be reloaded whenever it is empty or being drained in the
// same cycle, which gives one result per cycle with no bubble on drain+refill.

module basilisk_writeback_arbiter
    import basilisk_writeback_pkg::*;
#(
    parameter int NUM_PORTS        = 5,
    parameter int PORT_INDEX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    basilisk_writeback_arbiter_if.slave   bus
);

    localparam logic [PORT_INDEX_WIDTH-1:0] LAST_PORT = PORT_INDEX_WIDTH'(NUM_PORTS - 1);

    logic                          wb_valid_q,  wb_valid_d;
    basilisk_writeback_result_t    wb_data_q,   wb_data_d;
    logic [PORT_INDEX_WIDTH-1:0]   wb_source_q, wb_source_d;
    logic [15:0]                   wb_count_q,  wb_count_d;
    logic [PORT_INDEX_WIDTH-1:0]   rr_ptr_q,    rr_ptr_d;

    logic                          load;
    logic                          out_xfer;
    logic                          found;
    logic [PORT_INDEX_WIDTH-1:0]   winner;
    logic [NUM_PORTS-1:0]          grant;

    // The output register can take a new result when it is empty or is
    // handing its current result to the register file on this edge.
    assign load     = !wb_valid_q || bus.writeback_ready;
    assign out_xfer = wb_valid_q && bus.writeback_ready;

    // Rotating priority without a modulo: the lowest valid index at or above
    // rr_ptr wins; if none, wrap around to the lowest valid index overall.
    // Scanning downwards lets the last hit be the lowest index.
    always_comb begin
        logic                        hi_found;
        logic [PORT_INDEX_WIDTH-1:0] hi_idx;
        logic                        lo_found;
        logic [PORT_INDEX_WIDTH-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (bus.result_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = PORT_INDEX_WIDTH'(j);
                if (PORT_INDEX_WIDTH'(j) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PORT_INDEX_WIDTH'(j);
                end
            end
        end
        found  = lo_found;
        winner = hi_found ? hi_idx : lo_idx;
    end

    // Grant is suppressed during reset so no requester believes it handed
    // off a result that the reset is about to throw away.
    always_comb begin
        grant = '0;
        if (!rst && load && found) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_source_d = wb_source_q;
        rr_ptr_d    = rr_ptr_q;
        wb_count_d  = wb_count_q;

        if (out_xfer) begin
            wb_count_d = wb_count_q + 16'd1;
        end

        if (load) begin
            if (found) begin
                wb_valid_d  = 1'b1;
                wb_data_d   = bus.result_data[winner];
                wb_source_d = winner;
                rr_ptr_d    = (winner == LAST_PORT) ? '0 : winner + 1'b1;
            end else begin
                // Nothing to load: mark empty but keep payload and pointer.
                wb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_source_q <= '0;
            wb_count_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_source_q <= wb_source_d;
            wb_count_q  <= wb_count_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.result_ready     = grant;
    assign bus.writeback_valid  = wb_valid_q;
    assign bus.writeback_data   = wb_data_q;
    assign bus.writeback_source = wb_source_q;
    assign bus.writeback_count  = wb_count_q;

endmodule

// File: tb/tb_basilisk_writeback_arbiter.sv
// tb/tb_basilisk_writeback_arbiter.sv - self-checking bench for basilisk_writeback_arbiter

module tb_basilisk_writeback_arbiter;
    import basilisk_writeback_pkg::*;

    localparam int N   = 5;
    localparam int PIW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    basilisk_writeback_arbiter_if #(.NUM_PORTS(N)) bus();

    basilisk_writeback_arbiter #(.NUM_PORTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]    data;
        logic [PIW-1:0] src;
    } exp_t;

    typedef struct {
        logic         r;
        logic [N-1:0] v;
        logic         wr;
        logic [N-1:0] rdy;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    logic [15:0] exp_count = '0;
    logic [31:0] pdata [N];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PIW-1:0] onehot_index(input logic [N-1:0] oh);
        logic [PIW-1:0] idx;
        idx = '0;
        for (int j = 0; j < N; j++) begin
            if (oh[j]) idx = PIW'(j);
        end
        return idx;
    endfunction

    task automatic randomize_data();
        for (int p = 0; p < N; p++) pdata[p] = $urandom;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then advance the scoreboard to what the coming rising edge should do.
    task automatic step(input logic r, input logic [N-1:0] v, input logic wr,
                        input logic [N-1:0] exp_rdy, input bit chk);
        exp_t e;
        @(negedge clk);
        rst                 = r;
        bus.result_valid    = v;
        bus.writeback_ready = wr;
        for (int p = 0; p < N; p++) bus.result_data[p] = pdata[p];
        #1;
        if (chk) begin
            check("result_ready", 32'(bus.result_ready), 32'(exp_rdy));
            check("writeback_valid", 32'(bus.writeback_valid), 32'(sb.size() != 0));
            check("writeback_count", 32'(bus.writeback_count), 32'(exp_count));
            if (sb.size() != 0) begin
                check("writeback_data", bus.writeback_data, sb[0].data);
                check("writeback_source", 32'(bus.writeback_source), 32'(sb[0].src));
            end
        end
        if (r) begin
            sb.delete();
            exp_count = '0;
        end else begin
            if (sb.size() != 0 && wr) begin
                void'(sb.pop_front());
                exp_count++;
            end
            if (exp_rdy != '0) begin
                e.src  = onehot_index(exp_rdy);
                e.data = pdata[e.src];
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        // Round-robin from rr_ptr=0 over ports 0,1,3, then backpressure.
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b00001});
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b00010});
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b01000});
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b00001});
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b00010});
        vecs.push_back('{1'b0, 5'b01011, 1'b1, 5'b01000});
        vecs.push_back('{1'b0, 5'b00000, 1'b1, 5'b00000});
        vecs.push_back('{1'b0, 5'b11111, 1'b1, 5'b10000});
        vecs.push_back('{1'b0, 5'b11111, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 5'b11111, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 5'b11111, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 5'b11111, 1'b0, 5'b00000});
        vecs.push_back('{1'b0, 5'b11111, 1'b1, 5'b00001});
        vecs.push_back('{1'b0, 5'b00000, 1'b1, 5'b00000});
        vecs.push_back('{1'b0, 5'b00000, 1'b1, 5'b00000});

        randomize_data();
        step(1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0);
        step(1'b1, 5'b11111, 1'b1, 5'b00000, 1'b1);

        // Single requester on port 2.
        randomize_data();
        pdata[2] = 32'h3F800000;
        step(1'b0, 5'b00100, 1'b1, 5'b00100, 1'b1);
        randomize_data();
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("single_data", bus.writeback_data, 32'h3F800000);
        check("single_source", 32'(bus.writeback_source), 32'd2);
        check("single_count_before", 32'(bus.writeback_count), 32'd0);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("single_count_after", 32'(bus.writeback_count), 32'd1);

        step(1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1);
        foreach (vecs[k]) begin
            randomize_data();
            step(vecs[k].r, vecs[k].v, vecs[k].wr, vecs[k].rdy, 1'b1);
        end

        // Idle gap: port 4 then nothing; pointer wraps to 0.
        randomize_data();
        step(1'b0, 5'b10000, 1'b1, 5'b10000, 1'b1);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("idle_valid_drop", 32'(bus.writeback_valid), 32'd0);
        randomize_data();
        step(1'b0, 5'b10001, 1'b1, 5'b00001, 1'b1);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);

        // Reset mid-stream with a held result and count 7.
        step(1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            randomize_data();
            step(1'b0, 5'b00001, 1'b1, 5'b00001, 1'b1);
        end
        step(1'b1, 5'b11111, 1'b1, 5'b00000, 1'b1);
        check("mid_count_seven", 32'(bus.writeback_count), 32'd7);
        check("mid_valid_held", 32'(bus.writeback_valid), 32'd1);
        randomize_data();
        step(1'b0, 5'b11111, 1'b1, 5'b00001, 1'b1);
        check("mid_valid_cleared", 32'(bus.writeback_valid), 32'd0);
        check("mid_count_cleared", 32'(bus.writeback_count), 32'd0);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("mid_restart_source", 32'(bus.writeback_source), 32'd0);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);

        // Counter wrap after 65536 transfers.
        step(1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1);
        randomize_data();
        for (int i = 0; i < 65536; i++) begin
            step(1'b0, 5'b00001, 1'b1, 5'b00001, (i < 3) || (i > 65532));
        end
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("wrap_count_max", 32'(bus.writeback_count), 32'h0000FFFF);
        step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1);
        check("wrap_count_zero", 32'(bus.writeback_count), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
